// File: rtl/misao_mem_responder.sv
// Byte-wide memory responder for the MISA-O core: RAM, one I/O register,
// and a streaming boot loader that holds the core in reset until loaded.
module misao_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [14:0] IO_ADDR   = 15'h7FFF,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable_read,
    input  logic        mem_enable_write,
    input  logic [14:0] mem_addr,
    input  logic        mem_rw,
    input  logic [7:0]  mem_data_out,
    output logic [7:0]  mem_data_in,
    output logic        core_rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_overflow,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic        io_strobe,
    output logic        bus_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RELEASE,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    io_out_q, io_out_d;
    logic          ovf_q, ovf_d;
    logic          io_stb_q, io_stb_d;
    logic          err_q, err_d;

    logic [7:0]    mem_q [DEPTH];
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;

    logic [AW-1:0] mem_idx;
    logic          is_io;
    logic          in_ram;
    logic          ld_xfer;
    logic          wr;
    logic          rd;

    // The I/O address wins over RAM even when DEPTH covers the whole space.
    assign mem_idx = mem_addr[AW-1:0];
    assign is_io   = (mem_addr == IO_ADDR);
    assign in_ram  = (32'(mem_addr) < DEPTH) && !is_io;
    assign ld_xfer = ld_valid && ld_ready;
    assign wr      = mem_enable_write;
    assign rd      = mem_enable_read;

    assign ld_ready    = (state_q == S_LOAD) && !rst;
    assign core_rst    = (state_q != S_RUN);
    assign mem_data_in = rdata_q;
    assign ld_overflow = ovf_q;
    assign io_out      = io_out_q;
    assign io_strobe   = io_stb_q;
    assign bus_err     = err_q;

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        rdata_d   = rdata_q;
        io_out_d  = io_out_q;
        ovf_d     = ovf_q;
        io_stb_d  = 1'b0;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = ld_addr_q;
        ram_wdata = ld_data;
        case (state_q)
            S_LOAD: begin
                if (ld_xfer) begin
                    ram_we    = 1'b1;
                    ld_addr_d = ld_addr_q + AW'(1);
                    if (ld_addr_q == AW'(DEPTH - 1)) begin
                        ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (wr) begin
                    if (is_io) begin
                        io_out_d = mem_data_out;
                        io_stb_d = 1'b1;
                    end else if (in_ram) begin
                        ram_we    = 1'b1;
                        ram_waddr = mem_idx;
                        ram_wdata = mem_data_out;
                    end
                end
                // RAM array updates at the edge, so this is read-before-write.
                if (rd) begin
                    if (is_io) begin
                        rdata_d = io_in;
                    end else if (in_ram) begin
                        rdata_d = mem_q[mem_idx];
                    end else begin
                        rdata_d = 8'h00;
                    end
                end
                if ((wr && rd) || (wr && !mem_rw) || (rd && mem_rw)) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT_LOAD ? S_LOAD : S_RUN;
            ld_addr_q <= '0;
            rdata_q   <= 8'h00;
            io_out_q  <= 8'h00;
            ovf_q     <= 1'b0;
            io_stb_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            rdata_q   <= rdata_d;
            io_out_q  <= io_out_d;
            ovf_q     <= ovf_d;
            io_stb_q  <= io_stb_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_misao_mem_responder.sv
// Directed bench for misao_mem_responder: loader, RUN accesses, I/O,
// out-of-range handling, overflow and mid-load reset.
module tb_misao_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_enable_read;
    logic        mem_enable_write;
    logic [14:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        core_rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_overflow;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic        io_strobe;
    logic        bus_err;

    int total;
    int bad;
    logic [7:0] exp_q [$];

    misao_mem_responder #(
        .DEPTH(256),
        .IO_ADDR(15'h7FFF),
        .BOOT_LOAD(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_enable_read(mem_enable_read),
        .mem_enable_write(mem_enable_write),
        .mem_addr(mem_addr),
        .mem_rw(mem_rw),
        .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in),
        .core_rst(core_rst),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .ld_overflow(ld_overflow),
        .io_in(io_in),
        .io_out(io_out),
        .io_strobe(io_strobe),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Expected byte is queued at issue and retired when the data appears.
    task automatic rd(input logic [14:0] a, input logic [7:0] e,
                      input string tag);
        logic [7:0] want;
        exp_q.push_back(e);
        mem_enable_read = 1'b1;
        mem_rw          = 1'b0;
        mem_addr        = a;
        tick();
        mem_enable_read = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            want = exp_q.pop_front();
            chk(tag, 16'(mem_data_in), 16'(want));
        end
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        mem_enable_write = 1'b1;
        mem_rw           = 1'b1;
        mem_addr         = a;
        mem_data_out     = d;
        tick();
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
    endtask

    task automatic ld(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] img [3];
        img[0] = 8'h81;
        img[1] = 8'h0C;
        img[2] = 8'h34;
        total = 0;
        bad = 0;
        rst = 1'b1;
        mem_enable_read = 1'b0;
        mem_enable_write = 1'b0;
        mem_addr = '0;
        mem_rw = 1'b0;
        mem_data_out = '0;
        ld_valid = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        io_in = 8'h3C;
        tick();
        tick();
        chk("rst_core_rst", 16'(core_rst), 16'd1);
        chk("rst_ld_ready", 16'(ld_ready), 16'd0);
        chk("rst_ovf", 16'(ld_overflow), 16'd0);
        chk("rst_rdata", 16'(mem_data_in), 16'h00);
        chk("rst_io_out", 16'(io_out), 16'h00);
        chk("rst_io_strobe", 16'(io_strobe), 16'd0);
        chk("rst_bus_err", 16'(bus_err), 16'd0);

        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("load_ready%0d", i), 16'(ld_ready), 16'd1);
            ld(img[i], i == 2);
        end
        chk("release_ready", 16'(ld_ready), 16'd0);
        chk("release_core_rst", 16'(core_rst), 16'd1);
        tick();
        chk("run_core_rst", 16'(core_rst), 16'd0);

        rd(15'h0001, 8'h0C, "rd_1");
        tick();
        chk("rd_hold", 16'(mem_data_in), 16'h0C);
        rd(15'h0000, 8'h81, "rd_0");
        rd(15'h0002, 8'h34, "rd_2");
        chk("no_err_yet", 16'(bus_err), 16'd0);

        wr(15'h0010, 8'h00);
        mem_enable_read  = 1'b1;
        mem_enable_write = 1'b1;
        mem_rw           = 1'b1;
        mem_addr         = 15'h0010;
        mem_data_out     = 8'hA5;
        exp_q.push_back(8'h00);
        tick();
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
        chk("rbw_old", 16'(mem_data_in), 16'(exp_q.pop_front()));
        chk("rbw_err", 16'(bus_err), 16'd1);
        rd(15'h0010, 8'hA5, "rbw_new");

        wr(15'h00FF, 8'h77);
        wr(15'h7FFF, 8'h5A);
        chk("io_out", 16'(io_out), 16'h5A);
        chk("io_stb_hi", 16'(io_strobe), 16'd1);
        tick();
        chk("io_stb_lo", 16'(io_strobe), 16'd0);
        rd(15'h00FF, 8'h77, "io_ram_ff");
        rd(15'h7FFF, 8'h3C, "io_rd");
        wr(15'h7FFF, 8'h11);
        chk("io_b2b_1", 16'(io_strobe), 16'd1);
        wr(15'h7FFF, 8'h22);
        chk("io_b2b_2", 16'(io_strobe), 16'd1);
        chk("io_b2b_out", 16'(io_out), 16'h22);

        rd(15'h0100, 8'h00, "oor_rd");
        wr(15'h0100, 8'h99);
        rd(15'h0000, 8'h81, "oor_wr");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_err", 16'(bus_err), 16'd0);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("ovf_pre", 16'(ld_overflow), 16'd0);
            end
            ld(8'(i), 1'b0);
        end
        chk("ovf_set", 16'(ld_overflow), 16'd1);
        ld(8'hEE, 1'b1);
        tick();
        chk("ovf_run", 16'(core_rst), 16'd0);
        rd(15'h0000, 8'hEE, "ovf_ram0");
        rd(15'h0001, 8'h01, "ovf_ram1");
        rd(15'h0010, 8'h10, "ovf_ram10");
        chk("ovf_sticky", 16'(ld_overflow), 16'd1);

        chk("mm_pre", 16'(bus_err), 16'd0);
        mem_enable_write = 1'b1;
        mem_rw           = 1'b0;
        mem_addr         = 15'h0005;
        mem_data_out     = 8'h42;
        tick();
        mem_enable_write = 1'b0;
        chk("mm_err", 16'(bus_err), 16'd1);
        rd(15'h0005, 8'h42, "mm_exec");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld(8'hAA, 1'b0);
        ld(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_ovf", 16'(ld_overflow), 16'd0);
        chk("mid_err", 16'(bus_err), 16'd0);
        chk("mid_core_rst", 16'(core_rst), 16'd1);
        rst = 1'b0;
        ld(8'hCC, 1'b1);
        tick();
        rd(15'h0000, 8'hCC, "mid_addr0");
        rd(15'h0001, 8'hBB, "mid_addr1");
        rd(15'h0002, 8'h02, "mid_addr2");
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
